// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width, runtime parity (none/even/odd)
// and one or two stop bits. Every bit is taken as a 3-sample majority around
// mid-bit. Finished words are held in a one-entry valid/ready register.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | line idle, waiting for a synchronised low level
// ST_START     | start bit: confirm low at mid-bit, else reject as glitch
// ST_DATA      | shifting in DATA_W data bits, LSB first
// ST_PARITY    | sampling the parity bit (only when parity is enabled)
// ST_STOP      | sampling one or two stop bits, frame completes at mid-bit
// ST_WAIT_IDLE | after a framing error, hold until the line returns high
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_W       = 8
) (
   input  logic              i_Clock,
   input  logic              rst,
   input  logic              i_Rx_Serial,
   input  logic [1:0]        i_parity_mode,
   input  logic              i_two_stop,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_parity_err,
   output logic              o_frame_err,
   output logic              o_break,
   output logic              o_overrun,
   output logic              o_busy
);

   localparam int M     = (CLKS_PER_BIT - 1) / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_W);

   localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(M - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(M);
   localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(M + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
   logic [IDX_W-1:0]  bit_idx;
   logic              rx_meta, rx_sync;
   logic              samp_lo, samp_mid, maj;
   logic              at_hi, at_last;
   logic [DATA_W-1:0] shreg;
   logic              par_en, par_odd, two_stop;
   logic              par_bit, stop1_bit, stop_idx;
   logic              start_ok, frame_done;
   logic              first_stop, ferr_now, brk_now, perr_now;

   assign at_hi   = (cnt == CNT_HI);
   assign at_last = (cnt == CNT_LAST);
   assign cnt_inc = at_last ? '0 : cnt + 1'b1;
   assign maj     = (samp_lo & samp_mid) | (samp_lo & rx_sync) | (samp_mid & rx_sync);

   // The first stop bit was recorded earlier in two-stop mode; otherwise it is
   // the bit being decided right now.
   assign first_stop = two_stop ? stop1_bit : maj;
   assign ferr_now   = !maj || (two_stop && !stop1_bit);
   assign brk_now    = (shreg == '0) && !(par_en && par_bit) && !first_stop;
   assign perr_now   = par_en && (par_bit != (^shreg ^ par_odd));
   assign o_busy     = (state != ST_IDLE);

   // Two-flop synchroniser for the asynchronous serial line, idle high.
   always_ff @(posedge i_Clock or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_Rx_Serial;
         rx_sync <= rx_meta;
      end
   end

   // State and bit-period counter registers.
   always_ff @(posedge i_Clock or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic. Count 0 is the idle cycle that first sees the line low,
   // so the counter enters ST_START already at 1.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt_inc;
      start_ok   = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (!rx_sync) begin
               state_nxt = ST_START;
               cnt_nxt   = CNT_W'(1);
            end
         end
         ST_START: begin
            if (at_hi) begin
               if (maj) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else begin
                  start_ok = 1'b1;
               end
            end else if (at_last) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (at_last && (bit_idx == IDX_LAST))
               state_nxt = par_en ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (at_last)
               state_nxt = ST_STOP;
         end
         ST_STOP: begin
            // No wait for the end of the stop period, so a back-to-back
            // start edge is never missed.
            if (at_hi && (!two_stop || stop_idx)) begin
               frame_done = 1'b1;
               cnt_nxt    = '0;
               state_nxt  = ferr_now ? ST_WAIT_IDLE : ST_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            cnt_nxt = '0;
            if (rx_sync)
               state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Sample capture, frame configuration latch and data shift register.
   always_ff @(posedge i_Clock or negedge rst) begin
      if (!rst) begin
         samp_lo   <= 1'b0;
         samp_mid  <= 1'b0;
         shreg     <= '0;
         bit_idx   <= '0;
         par_en    <= 1'b0;
         par_odd   <= 1'b0;
         two_stop  <= 1'b0;
         par_bit   <= 1'b0;
         stop1_bit <= 1'b0;
         stop_idx  <= 1'b0;
      end else begin
         if (cnt == CNT_LO)
            samp_lo <= rx_sync;
         if (cnt == CNT_MID)
            samp_mid <= rx_sync;
         if (start_ok) begin
            par_en   <= (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
            par_odd  <= (i_parity_mode == 2'b10);
            two_stop <= i_two_stop;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
         end
         if (state == ST_DATA) begin
            if (at_hi)
               shreg <= {maj, shreg[DATA_W-1:1]};
            if (at_last)
               bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
         end
         if ((state == ST_PARITY) && at_hi)
            par_bit <= maj;
         if ((state == ST_STOP) && two_stop && !stop_idx) begin
            if (at_hi)
               stop1_bit <= maj;
            if (at_last)
               stop_idx <= 1'b1;
         end
      end
   end

   // One-entry output register: load when empty or being drained, otherwise
   // drop the new frame and flag an overrun for one cycle.
   always_ff @(posedge i_Clock or negedge rst) begin
      if (!rst) begin
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (frame_done) begin
            if (!o_valid || i_ready) begin
               o_valid      <= 1'b1;
               o_data       <= shreg;
               o_parity_err <= perr_now;
               o_frame_err  <= ferr_now;
               o_break      <= brk_now;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule
